ila_capture: RTL and testbench
==============================

ILA_CAPTURE -- requirements
Module: ila_capture

Interface
REQ-001 Parameter SAMPLE_W, default 25, width of the sampled DUT bus.
REQ-002 Parameter DEPTH, default 64, capture buffer depth in samples; power of two, at least 4.
REQ-003 Parameter PRE_TRIG, default 16, number of samples retained before the trigger sample; range 0 to DEPTH-1.
REQ-004 clk  input  1  single clock; the sample bus is synchronous to it.
REQ-005 ILA_rst  input  1  synchronous, active-high reset.
REQ-006 sample  input  SAMPLE_W  DUT sample bus (the ila_sample_dut output of the DUT).
REQ-007 arm  input  1  one-cycle pulse that starts a capture; honoured only in IDLE.
REQ-008 trig_value  input  SAMPLE_W  trigger compare value.
REQ-009 trig_mask  input  SAMPLE_W  per-bit compare enable; 1 means the bit is compared.
REQ-010 rd_en  input  1  readout request, one sample per asserted cycle.
REQ-011 rd_data  output  SAMPLE_W  readout sample.
REQ-012 rd_valid  output  1  rd_data is valid this cycle.
REQ-013 state  output  2  current state: IDLE=0, PRE=1, POST=2, DONE=3.
REQ-014 triggered  output  1  high from the trigger cycle until the capture is fully read out.

Function
REQ-015 Trigger match SHALL be combinational: (sample & trig_mask) == (trig_value & trig_mask); an all-zero mask SHALL match every cycle.
REQ-016 In IDLE, an arm pulse SHALL move the FSM to PRE at the next edge and clear wr_ptr, pre_cnt and rd_cnt; no sample is written in the arm cycle.
REQ-017 In PRE and POST, the current sample SHALL be written to buffer[wr_ptr] at each edge, and wr_ptr SHALL increment modulo DEPTH (wrap-around).
REQ-018 In PRE, pre_cnt SHALL count writes and saturate at PRE_TRIG; a match SHALL be accepted only when pre_cnt == PRE_TRIG, and a match before that SHALL be ignored.
REQ-019 On an accepted match, the following SHALL happen:
- the trigger sample is written;
- triggered goes to 1 at the next edge;
- post_cnt loads DEPTH-PRE_TRIG-1;
- the FSM goes to POST, or directly to DONE if DEPTH-PRE_TRIG-1 == 0.
REQ-020 In POST, each write SHALL decrement post_cnt, and the FSM SHALL enter DONE at the edge that writes the last post sample.
REQ-021 On entering DONE, the buffer SHALL hold exactly DEPTH samples: PRE_TRIG pre-trigger samples, the trigger sample, and DEPTH-PRE_TRIG-1 post-trigger samples.
REQ-022 Readout SHALL start at address wr_ptr (the oldest sample) and proceed in chronological order.
REQ-023 In DONE, rd_en SHALL produce rd_data from the next read address one cycle later, with rd_valid high for exactly that cycle.
REQ-024 rd_en on consecutive cycles SHALL give back-to-back valid samples.
REQ-025 After the DEPTH-th read is issued, the FSM SHALL return to IDLE at that edge and triggered SHALL clear; the final rd_valid still SHALL appear in the following cycle.
REQ-026 rd_en outside DONE SHALL be ignored, and rd_valid SHALL stay 0.
REQ-027 arm outside IDLE SHALL be ignored; arm and rd_en in the same cycle SHALL follow the current-state rules only.
REQ-028 The buffer SHALL be inferable as simple dual-port RAM: one synchronous write port and one synchronous read port.

Reset
REQ-029 ILA_rst high at an edge SHALL force, at any point of operation including mid-PRE, mid-POST and mid-readout:
- state = IDLE;
- triggered = 0, rd_valid = 0, rd_data = 0;
- wr_ptr, pre_cnt, post_cnt, rd_cnt = 0.
REQ-030 Buffer contents SHALL NOT require reset, and ILA_rst SHALL take priority over arm and rd_en.

Verification (SAMPLE_W=25, DEPTH=64, PRE_TRIG=16; sample = free-running counter, +1 per cycle)
REQ-031 Basic capture: trig_mask=all ones, trig_value=100, arm while sample=10 -> trigger on 100; DONE after sample 147; 64 reads return 84..147 in order.
REQ-032 Immediate trigger: trig_mask=0, arm while sample=10 -> writes start at 11; trigger on 27; 64 reads return 11..74.
REQ-033 Early match ignored: trig_mask=0x1F, trig_value=20, arm while sample=10 -> match at 20 ignored (pre not filled); trigger on 52; reads return 36..99.
REQ-034 Readout protocol:
- rd_en with gaps gives rd_valid exactly one cycle after each rd_en;
- rd_en in IDLE, PRE or POST gives no rd_valid;
- after the 64th read, state = 0 and triggered = 0;
- a 65th rd_en gives no rd_valid.
REQ-035 Reset mid-operation: ILA_rst during POST -> next cycle state=0, triggered=0, rd_valid=0; a new arm then performs a complete, correct capture.
REQ-036 Re-arm rejection: arm pulses during PRE, POST and DONE -> no change of state, wr_ptr or captured data.

Source files
------------

// File: rtl/ila_capture.sv
// Trigger-based logic analyser capture: a circular sample buffer with pre-trigger history,
// a masked equality trigger, and a chronological readout port after the capture completes.
module ila_capture #(
  parameter int SAMPLE_W = 25,
  parameter int DEPTH    = 64,
  parameter int PRE_TRIG = 16
) (
  input  logic                clk,
  input  logic                ILA_rst,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                arm,
  input  logic [SAMPLE_W-1:0] trig_value,
  input  logic [SAMPLE_W-1:0] trig_mask,
  input  logic                rd_en,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_valid,
  output logic [1:0]          state,
  output logic                triggered
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG);
  localparam logic [AW-1:0] POST_LOAD = AW'(DEPTH - PRE_TRIG - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_POST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          st;
  logic [AW-1:0]       wr_ptr, pre_cnt, post_cnt, rd_cnt, rd_addr;
  logic                hit, wr_en, rd_fire, last_rd;
  logic [SAMPLE_W-1:0] mem [DEPTH];

  assign hit     = ((sample ^ trig_value) & trig_mask) == '0;
  assign wr_en   = (st == S_PRE) || (st == S_POST);
  assign rd_fire = (st == S_DONE) && rd_en;
  // Exactly DEPTH writes follow the oldest retained sample, so wr_ptr points at it in DONE.
  assign rd_addr = wr_ptr + rd_cnt;
  assign last_rd = rd_fire && (rd_cnt == AW'(DEPTH - 1));
  assign state   = st;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample;
  end

  always_ff @(posedge clk) begin
    if (ILA_rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (ILA_rst) begin
      st        <= S_IDLE;
      triggered <= 1'b0;
      wr_ptr    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      rd_cnt    <= '0;
    end else begin
      case (st)
        S_IDLE: if (arm) begin
          st      <= S_PRE;
          wr_ptr  <= '0;
          pre_cnt <= '0;
          rd_cnt  <= '0;
        end
        S_PRE: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (pre_cnt == PRE_LAST && hit) begin
            triggered <= 1'b1;
            post_cnt  <= POST_LOAD;
            st        <= (POST_LOAD == '0) ? S_DONE : S_POST;
          end else if (pre_cnt != PRE_LAST) begin
            pre_cnt <= pre_cnt + 1'b1;
          end
        end
        S_POST: begin
          wr_ptr   <= wr_ptr + 1'b1;
          post_cnt <= post_cnt - 1'b1;
          if (post_cnt == AW'(1)) st <= S_DONE;
        end
        default: begin
          if (rd_fire) rd_cnt <= rd_cnt + 1'b1;
          if (last_rd) begin
            st        <= S_IDLE;
            triggered <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ila_capture.sv
// Capture/readout bench: table of capture scenarios, scoreboard queue of expected read data,
// plus hand sequences for reset and re-arm corner cases.
module tb_ila_capture;
  localparam int W = 25;

  logic         clk = 1'b0;
  logic         ILA_rst = 1'b1;
  logic [W-1:0] smp = '0;
  logic         arm = 1'b0;
  logic [W-1:0] trig_value = '0;
  logic [W-1:0] trig_mask = '0;
  logic         rd_en = 1'b0;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic [1:0]   state;
  logic         triggered;

  ila_capture #(.SAMPLE_W(W), .DEPTH(64), .PRE_TRIG(16)) dut (
    .clk(clk), .ILA_rst(ILA_rst), .sample(smp), .arm(arm),
    .trig_value(trig_value), .trig_mask(trig_mask), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .state(state), .triggered(triggered)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] mask;
    logic [W-1:0] value;
    logic [W-1:0] arm_smp;
    int           trig;
    int           done;
    int           first;
    bit           gaps;
    bit           poke;
  } vec_t;

  vec_t         vecs [4];
  logic [W-1:0] q [$];
  logic [W-1:0] last_smp;
  int           pass_n = 0;
  int           total_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // One clock: look at outputs just after the edge, then advance the free-running sample.
  task automatic tick();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    last_smp = smp;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rd_valid", 32'(rd_valid), 1);
      chk("rd_data", 32'(rd_data), 32'(e));
    end else begin
      chk("no_rd_valid", 32'(rd_valid), 0);
    end
    smp = smp + 1'b1;
  endtask

  task automatic run_vec(input int i);
    int  trig_at, done_at;
    bit  pp, pq;
    trig_mask  = vecs[i].mask;
    trig_value = vecs[i].value;
    smp        = vecs[i].arm_smp;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_to_pre", 32'(state), 1);
    trig_at = -1; done_at = -1; pp = 0; pq = 0;
    for (int c = 0; c < 10000 && done_at < 0; c++) begin
      if (vecs[i].poke && state == 2'd1 && !pp) begin arm = 1'b1; rd_en = 1'b1; pp = 1; end
      else if (vecs[i].poke && state == 2'd2 && !pq) begin arm = 1'b1; rd_en = 1'b1; pq = 1; end
      tick();
      arm = 1'b0; rd_en = 1'b0;
      if (triggered && trig_at < 0) trig_at = int'(last_smp);
      if (state == 2'd3) done_at = int'(last_smp);
    end
    chk("trigger_sample", 32'(trig_at), 32'(vecs[i].trig));
    chk("done_sample", 32'(done_at), 32'(vecs[i].done));
    chk("triggered_in_done", 32'(triggered), 1);
    for (int k = 0; k < 64; k++) begin
      if (vecs[i].gaps && (k % 2 == 1)) tick();
      rd_en = 1'b1;
      q.push_back(W'(vecs[i].first + k));
      if (vecs[i].poke && k == 10) arm = 1'b1;
      tick();
      rd_en = 1'b0; arm = 1'b0;
      if (k == 10 || k == 62) chk("state_done_during_read", 32'(state), 3);
    end
    chk("idle_after_last_read", 32'(state), 0);
    chk("triggered_cleared", 32'(triggered), 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("idle_after_extra_read", 32'(state), 0);
  endtask

  initial begin
    vecs[0] = '{mask: '1,        value: W'(100),    arm_smp: W'(10),     trig: 100,  done: 147,  first: 84,   gaps: 0, poke: 1};
    vecs[1] = '{mask: '0,        value: W'(0),      arm_smp: W'(10),     trig: 27,   done: 74,   first: 11,   gaps: 1, poke: 0};
    vecs[2] = '{mask: W'('h1F),  value: W'(20),     arm_smp: W'(10),     trig: 52,   done: 99,   first: 36,   gaps: 0, poke: 0};
    vecs[3] = '{mask: W'('h1F00), value: W'('h300), arm_smp: W'('h22F0), trig: 8961, done: 9008, first: 8945, gaps: 1, poke: 0};

    tick();
    tick();
    chk("reset_state", 32'(state), 0);
    chk("reset_triggered", 32'(triggered), 0);
    chk("reset_rd_valid", 32'(rd_valid), 0);
    chk("reset_rd_data", 32'(rd_data), 0);
    ILA_rst = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("idle_rd_ignored", 32'(state), 0);

    for (int i = 0; i < 4; i++) run_vec(i);

    // Reset in the middle of POST, with arm and rd_en also asserted.
    trig_mask = '1; trig_value = W'(100); smp = W'(10);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int c = 0; c < 300 && state != 2'd2; c++) tick();
    chk("reached_post", 32'(state), 2);
    tick();
    ILA_rst = 1'b1; arm = 1'b1; rd_en = 1'b1;
    tick();
    ILA_rst = 1'b0; arm = 1'b0; rd_en = 1'b0;
    chk("rst_post_state", 32'(state), 0);
    chk("rst_post_triggered", 32'(triggered), 0);
    chk("rst_post_rd_valid", 32'(rd_valid), 0);
    run_vec(0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
